reg_file_mp: RTL

Parametrised multi-read-port register file for the MIPS datapath with asynchronous active-low reset, write-to-read bypass, optional hardwired zero register, and a handshaked debug dump port. The dump port streams every register out one per beat for the testbench or trace logger. The block sits in the decode stage and drives operand buses for `NUM_RD` consumers. Writeback from the final pipeline stage feeds its single write port.

---
 rtl/reg_file_mp.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Multi-read-port register file with write bypass, optional
//               hardwired zero register and a handshaked debug dump stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_INIT  = 32'h0000_1FFF
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] Read_Reg,
    output logic [NUM_RD*DATA_W-1:0] Read_Data,
    input  logic [ADDR_W-1:0]        Write_Reg,
    input  logic [DATA_W-1:0]        Write_Data,
    input  logic                     Reg_Write,
    input  logic                     Dump_Req,
    input  logic                     Dump_Ready,
    output logic                     Dump_Valid,
    output logic [ADDR_W-1:0]        Dump_Index,
    output logic [DATA_W-1:0]        Dump_Data,
    output logic                     Dump_Busy,
    output logic                     Dump_Done
);

    localparam int                c_DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(c_DEPTH - 1);
    localparam logic [DATA_W-1:0] c_SP    = DATA_W'(SP_INIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_dump_index;
    logic [DATA_W-1:0] r_dump_data;
    logic              w_capture;
    logic [ADDR_W-1:0] w_cap_idx;
    logic [DATA_W-1:0] w_cap_data;
    logic              w_we;

    assign w_we = Reg_Write && !(ZERO_REG && (Write_Reg == '0));

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i[ADDR_W-1:0]] <= (i == SP_INDEX) ? c_SP : '0;
            end
        end else if (w_we) begin
            r_mem[Write_Reg] <= Write_Data;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports with same-cycle write bypass
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_idx;
            logic [DATA_W-1:0] w_data;

            assign w_idx = Read_Reg[k*ADDR_W +: ADDR_W];

            always_comb begin
                w_data = r_mem[w_idx];
                if (Reg_Write && (Write_Reg == w_idx)) begin
                    w_data = Write_Data;
                end
                if (ZERO_REG && (w_idx == '0)) begin
                    w_data = '0;
                end
            end

            assign Read_Data[k*DATA_W +: DATA_W] = w_data;
        end
    endgenerate

    // Snapshot source for the dump: same bypass rule as the read ports
    assign w_cap_idx = (r_state == S_IDLE) ? '0 : (r_dump_index + ADDR_W'(1));

    always_comb begin
        w_cap_data = r_mem[w_cap_idx];
        if (Reg_Write && (Write_Reg == w_cap_idx)) begin
            w_cap_data = Write_Data;
        end
        if (ZERO_REG && (w_cap_idx == '0)) begin
            w_cap_data = '0;
        end
    end

    // ------------------------------------------------------------------
    // Dump FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Dump_Req) begin
                    w_state_nxt = S_STREAM;
                    w_capture   = 1'b1;
                end
            end
            S_STREAM: begin
                if (Dump_Ready) begin
                    if (r_dump_index == c_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_capture = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Index and data only move on capture, so a stalled beat stays frozen
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dump_index <= '0;
            r_dump_data  <= '0;
        end else if (w_capture) begin
            r_dump_index <= w_cap_idx;
            r_dump_data  <= w_cap_data;
        end
    end

    assign Dump_Valid = (r_state == S_STREAM);
    assign Dump_Busy  = (r_state == S_STREAM);
    assign Dump_Done  = (r_state == S_DONE);
    assign Dump_Index = r_dump_index;
    assign Dump_Data  = r_dump_data;

endmodule

`default_nettype wire
